// File: rtl/snake_key_debounce.sv
// Four-key synchroniser/debouncer for the snake game: single-cycle press pulses plus debounced levels.
// Optional auto-repeat while a key is held is enabled by defining AUTO_REPEAT_EN.
module snake_key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned REPEAT_DELAY    = 25_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic       Clk_50mhz,
  input  logic       Rst_n,
  input  logic       Key_left_n,
  input  logic       Key_right_n,
  input  logic       Key_up_n,
  input  logic       Key_down_n,
  output logic       Key_left,
  output logic       Key_right,
  output logic       Key_up,
  output logic       Key_down,
  output logic [3:0] Key_level
);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int unsigned CNT_MAX = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
`else
  localparam int unsigned CNT_MAX = DEBOUNCE_CYCLES;
`endif
  localparam int unsigned CW = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("snake_key_debounce: illegal timing parameter");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  // Bit order {up, down, left, right} matches Key_level.
  logic [3:0] w_raw;
  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_pulse;
  logic [3:0] w_level;

  assign w_raw = {Key_up_n, Key_down_n, Key_left_n, Key_right_n};

  always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
    if (!Rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_key
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_pulse;
    logic          w_pulse_nxt;
    logic          r_level;
    logic          w_s;

    assign w_s        = r_sync2[k];
    assign w_pulse[k] = r_pulse;
    assign w_level[k] = r_level;

`ifdef AUTO_REPEAT_EN
    // The debounce counter is idle in PRESSED, so it doubles as the repeat timer there.
    logic          r_rep_phase;
    logic          w_rep_phase_nxt;
    logic [CW-1:0] w_rep_lim;
    assign w_rep_lim = r_rep_phase ? CW'(REPEAT_PERIOD - 1) : CW'(REPEAT_DELAY - 1);

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
      if (!Rst_n) r_rep_phase <= 1'b0;
      else        r_rep_phase <= w_rep_phase_nxt;
    end
`endif

    always_ff @(posedge Clk_50mhz or negedge Rst_n) begin
      if (!Rst_n) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_pulse <= 1'b0;
        r_level <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_pulse <= w_pulse_nxt;
        r_level <= (w_state_nxt == PRESSED) || (w_state_nxt == RELEASE_WAIT);
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pulse_nxt = 1'b0;
`ifdef AUTO_REPEAT_EN
      w_rep_phase_nxt = r_rep_phase;
`endif
      case (r_state)
        IDLE: begin
          if (!w_s) begin
            w_state_nxt = PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (w_s) begin
            w_state_nxt = IDLE;
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            w_state_nxt = PRESSED;
            w_pulse_nxt = 1'b1;
            w_cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
            w_rep_phase_nxt = 1'b0;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        PRESSED: begin
          if (w_s) begin
            w_state_nxt = RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end
`ifdef AUTO_REPEAT_EN
          else if (r_cnt == w_rep_lim) begin
            w_pulse_nxt     = 1'b1;
            w_cnt_nxt       = '0;
            w_rep_phase_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
`endif
        end
        RELEASE_WAIT: begin
          if (!w_s) begin
            w_state_nxt = PRESSED;
            w_cnt_nxt   = '0;
`ifdef AUTO_REPEAT_EN
            w_rep_phase_nxt = 1'b0;
`endif
          end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign Key_up    = w_pulse[3];
  assign Key_down  = w_pulse[2];
  assign Key_left  = w_pulse[1];
  assign Key_right = w_pulse[0];
  assign Key_level = w_level;

endmodule

// File: tb/tb_snake_key_debounce.sv
// Bench for snake_key_debounce: directed scenarios plus random bouncing keys, checked against a
// streak-counting reference model (define AUTO_REPEAT_EN to cover the repeat build).
module tb_snake_key_debounce;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 5;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_left_n  = 1'b1;
  logic       key_right_n = 1'b1;
  logic       key_up_n    = 1'b1;
  logic       key_down_n  = 1'b1;
  logic       key_left, key_right, key_up, key_down;
  logic [3:0] key_level;

  always #5 clk = ~clk;

  snake_key_debounce #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) u_dut (
    .Clk_50mhz  (clk),
    .Rst_n      (rst_n),
    .Key_left_n (key_left_n),
    .Key_right_n(key_right_n),
    .Key_up_n   (key_up_n),
    .Key_down_n (key_down_n),
    .Key_left   (key_left),
    .Key_right  (key_right),
    .Key_up     (key_up),
    .Key_down   (key_down),
    .Key_level  (key_level)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  int pc[4];
  int first_cyc[4];
  int fall_cyc[4];

  // Reference model: a key toggles once the synchronised input has disagreed with the
  // debounced level for D+1 consecutive edges; repeat timing counts edges held since (re)entry.
  logic [3:0] m_d1, m_d2, m_lvl, m_pulse;
  int         m_streak[4];
  int         m_hold[4];

  function automatic void model_reset();
    m_d1 = '1; m_d2 = '1; m_lvl = '0; m_pulse = '0;
    for (int k = 0; k < 4; k++) begin
      m_streak[k] = 0;
      m_hold[k]   = 0;
    end
  endfunction

  function automatic void model_edge(input logic [3:0] raw);
    logic [3:0] s;
    logic       opp;
    logic       was_pressed;
    s = m_d2; m_d2 = m_d1; m_d1 = raw; m_pulse = '0;
    for (int k = 0; k < 4; k++) begin
      opp         = m_lvl[k] ? s[k] : ~s[k];
      was_pressed = m_lvl[k] && (m_streak[k] == 0);
      if (opp) m_streak[k]++;
      else begin
        if (m_lvl[k] && m_streak[k] > 0) m_hold[k] = 0;
        m_streak[k] = 0;
      end
      if (m_streak[k] == D + 1) begin
        m_lvl[k]    = ~m_lvl[k];
        m_streak[k] = 0;
        m_hold[k]   = 0;
        m_pulse[k]  = m_lvl[k];
      end else if (was_pressed && opp) begin
        m_hold[k] = 0;
      end
`ifdef AUTO_REPEAT_EN
      else if (was_pressed) begin
        m_hold[k]++;
        if (m_hold[k] == RD || (m_hold[k] > RD && (m_hold[k] - RD) % RP == 0)) m_pulse[k] = 1'b1;
      end
`endif
    end
  endfunction

  task automatic check_outputs();
    n_vec++;
    assert ({key_up, key_down, key_left, key_right} === m_pulse) else begin
      n_miss++;
      $error("FAIL pulses cyc=%0d observed=%b expected=%b", cyc, {key_up, key_down, key_left, key_right}, m_pulse);
    end
    n_vec++;
    assert (key_level === m_lvl) else begin
      n_miss++;
      $error("FAIL level cyc=%0d observed=%b expected=%b", cyc, key_level, m_lvl);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      pc[k] = 0; first_cyc[k] = -1; fall_cyc[k] = -1;
    end
  endtask

  // raw = {up, down, left, right}, 0 = pressed; called and returns at a falling edge
  task automatic step(input logic [3:0] raw);
    logic [3:0] prev_lvl;
    prev_lvl = key_level;
    {key_up_n, key_down_n, key_left_n, key_right_n} = raw;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(raw);
    #1;
    check_outputs();
    for (int k = 0; k < 4; k++) begin
      if ({key_up, key_down, key_left, key_right} & (4'b0001 << k)) begin
        if (pc[k] == 0) first_cyc[k] = cyc;
        pc[k]++;
      end
      if (prev_lvl[k] && !key_level[k]) fall_cyc[k] = cyc;
    end
    @(negedge clk);
  endtask

  int t0;
  int rel;
  int pc_hold;
  logic [3:0] r_val;
  int         r_len[4];

  initial begin
    model_reset();
    clear_stats();
    #2 rst_n = 1'b0;
    #1 check_outputs();
    @(negedge clk);
    repeat (3) step(4'b1111);
    rst_n = 1'b1;

    // idle after reset
    repeat (50) step(4'b1111);
    check_int("idle_pulses", pc[0] + pc[1] + pc[2] + pc[3], 0);

    // up held: pulse on edge t0+6
    clear_stats();
    t0 = cyc + 1;
    repeat (20) step(4'b0111);
    check_int("up_latency", first_cyc[3], t0 + 6);
`ifdef AUTO_REPEAT_EN
    check_int("up_held_pulses", pc[3], 2);
`else
    check_int("up_held_pulses", pc[3], 1);
`endif
    repeat (12) step(4'b1111);

    // left bounce rejected
    clear_stats();
    repeat (3) step(4'b1101);
    repeat (10) step(4'b1111);
    check_int("left_bounce_pulses", pc[1], 0);

    // right held, released with glitch inside release wait
    clear_stats();
    repeat (10) step(4'b1110);
    repeat (3) step(4'b1111);
    repeat (2) step(4'b1110);
    rel = cyc + 1;
    repeat (10) step(4'b1111);
    check_int("right_pulses", pc[0], 1);
    check_int("right_fall", fall_cyc[0], rel + 6);

    // down and left together
    clear_stats();
    t0 = cyc + 1;
    repeat (10) step(4'b1001);
    check_int("down_latency", first_cyc[2], t0 + 6);
    check_int("left_latency", first_cyc[1], t0 + 6);
    repeat (12) step(4'b1111);

    // reset in the middle of a press count
    repeat (4) step(4'b0111);
    rst_n = 1'b0;
    model_reset();
    #1 check_outputs();
    repeat (2) step(4'b0111);
    rst_n = 1'b1;
    clear_stats();
    t0 = cyc + 1;
    repeat (10) step(4'b0111);
    check_int("post_reset_latency", first_cyc[3], t0 + 6);
    check_int("post_reset_pulses", pc[3], 1);
    repeat (12) step(4'b1111);

    // long hold: auto-repeat timing when enabled, single pulse otherwise
    clear_stats();
    repeat (47) step(4'b0111);
`ifdef AUTO_REPEAT_EN
    check_int("long_hold_pulses", pc[3], 8);
`else
    check_int("long_hold_pulses", pc[3], 1);
`endif
    pc_hold = pc[3];
    repeat (20) step(4'b1111);
    check_int("after_release_pulses", pc[3], pc_hold);

    // random bouncing keys
    r_val = 4'b1111;
    for (int k = 0; k < 4; k++) r_len[k] = 1;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 4; k++) begin
        r_len[k]--;
        if (r_len[k] <= 0) begin
          r_val[k] = $urandom_range(0, 1) != 0;
          r_len[k] = $urandom_range(1, 9);
        end
      end
      step(r_val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
